// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a small byte FIFO in front of the serialiser.
// Back-to-back frames are sent with no idle bit between the stop bit and the next start bit.
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W        = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic              baud_wrap;
  logic              have_byte;
  logic [7:0]        head;

  // in_ready looks only at registered state, so a pop in the same cycle never opens a full FIFO.
  assign in_ready   = rst_n && (count_q < FIFO_FULL);
  assign push       = in_valid && in_ready;
  assign have_byte  = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign baud_wrap  = (baud_q == BAUD_LAST);

  assign serial_tx  = tx_q;
  assign busy       = (state_q != S_IDLE) || have_byte;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (have_byte) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          baud_d = '0;
          if (have_byte) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same edge as the state.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage carries no reset; control state alone decides what is valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue/position line model checked every cycle, a mid-bit line decoder,
// and directed scenarios with hand-computed timing and bit patterns.
module tb_uart_tx;

  localparam int CPB_A = 10;
  localparam int CPB_B = 500;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;
  bit saw_stall = 0;

  logic [7:0] rxa[$];
  logic [7:0] rxb[$];
  logic [7:0] exp_q[$];

  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_act = 0;
  int         m_pos = 0;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .serial_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .serial_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Model: a byte queue plus the position inside the frame currently on the line.
  task automatic model_step();
    bit acc;
    if (!rst_n) begin
      m_q.delete();
      m_act = 0;
      m_pos = 0;
    end else begin
      acc = in_valid_a && (m_q.size() < 4);
      if (m_act) begin
        m_pos++;
        if (m_pos == 10 * CPB_A) m_act = 0;
      end
      if (!m_act && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_act = 1;
        m_pos = 0;
      end
      if (acc) m_q.push_back(in_data_a);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_tx", tx_a, m_act ? frame_bit(m_cur, m_pos / CPB_A) : 1'b1);
        chk("m_count", cnt_a, m_q.size());
        chk("m_busy", busy_a, (m_act || m_q.size() > 0) ? 1 : 0);
        chk("m_ready", in_ready_a, (rst_n && m_q.size() < 4) ? 1 : 0);
      end
    end
  end

  function automatic logic line_of(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  task automatic rx_wait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        ab = 1;
        return;
      end
    end
  endtask

  task automatic rx_decode(input int which, input int cpb);
    logic       prev;
    logic       s;
    logic [7:0] b;
    bit         ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      s = line_of(which);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && !s) begin
        ab = 0;
        b  = '0;
        for (int slot = 0; slot < 10; slot++) begin
          rx_wait((slot == 0) ? cpb / 2 : cpb, ab);
          if (ab) break;
          s = line_of(which);
          if (slot == 0)      chk((which != 0) ? "b_start_bit" : "a_start_bit", s, 0);
          else if (slot == 9) chk((which != 0) ? "b_stop_bit" : "a_stop_bit", s, 1);
          else                b[slot-1] = s;
        end
        if (!ab) begin
          if (which != 0) rxb.push_back(b);
          else            rxa.push_back(b);
        end
        prev = 1'b1;
      end else begin
        prev = s;
      end
    end
  endtask

  initial rx_decode(0, CPB_A);
  initial rx_decode(1, CPB_B);

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_a(input logic [7:0] d, output int k);
    in_data_a  = d;
    in_valid_a = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    in_valid_a = 1'b0;
  endtask

  task automatic push_wait(input int which, input logic [7:0] d);
    bit ok;
    if (which != 0) begin in_data_b = d; in_valid_b = 1'b1; end
    else            begin in_data_a = d; in_valid_a = 1'b1; end
    for (int t = 0; t < 2000; t++) begin
      ok = (which != 0) ? in_ready_b : in_ready_a;
      @(posedge clk);
      #1;
      if (ok) return;
      saw_stall = 1;
    end
    total++;
    bad++;
    $display("FAIL push_wait byte=%0d never accepted", d);
  endtask

  function automatic bit ev(input int kind);
    case (kind)
      0:       return !tx_a;
      1:       return !busy_a;
      2:       return !tx_b;
      default: return !busy_b;
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int limit, output int c);
    c = -1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (ev(kind)) begin
        c = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_ev kind=%0d timed out after %0d cycles", kind, limit);
  endtask

  task automatic chk_rx(input string nm, input int which);
    logic [7:0] got[$];
    got = (which != 0) ? rxb : rxa;
    chk({nm, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(nm, (i < got.size()) ? int'(got[i]) : -1, exp_q[i]);
    end
  endtask

  int k, k0, k1, k2, k3, pos, tgt, s, e, dummy;
  int a5_lv[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = '0;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx_a, 1);
    chk("reset_busy", busy_a, 0);
    chk("reset_count", cnt_a, 0);
    chk("reset_ready", in_ready_a, 0);
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", in_ready_a, 1);
    chk("release_tx", tx_a, 1);

    // Single byte 0xA5.
    @(posedge clk); #1;
    rxa.delete();
    push_a(8'hA5, k);
    @(negedge clk);
    chk("single_count_after_push", cnt_a, 1);
    chk("single_tx_after_push", tx_a, 1);
    @(negedge clk);
    chk("single_start_latency", tx_a, 0);
    chk("single_count_after_pop", cnt_a, 0);
    pos = k + 1;
    for (int i = 0; i < 10; i++) begin
      tgt = k + 1 + CPB_A * i + CPB_A / 2;
      repeat (tgt - pos) @(negedge clk);
      pos = tgt;
      chk("single_a5_level", tx_a, a5_lv[i]);
    end
    repeat (k + 100 - pos) @(negedge clk);
    chk("single_busy_last_stop", busy_a, 1);
    @(negedge clk);
    chk("single_busy_drop", busy_a, 0);
    exp_q.delete(); exp_q.push_back(8'hA5);
    chk_rx("single_rx", 0);

    // Burst of six bytes with in_valid held high.
    @(posedge clk); #1;
    rxa.delete();
    saw_stall = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          push_wait(0, 8'(i));
          if (i == 5) begin
            chk("burst_full_count", cnt_a, 4);
            chk("burst_full_ready", in_ready_a, 0);
          end
        end
        in_valid_a = 1'b0;
      end
      begin
        wait_ev(0, 200, s);
        wait_ev(1, 1000, e);
      end
    join
    chk("burst_line_time", e - s, 600);
    chk("burst_stall_seen", saw_stall, 1);
    exp_q.delete();
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    chk_rx("burst_rx", 0);

    // Push landing on the same edge as the STOP->START pop.
    @(posedge clk); #1;
    rxa.delete();
    push_a(8'h11, k0);
    push_a(8'h22, k1);
    push_a(8'h33, k2);
    chk("pp_count_before", cnt_a, 2);
    repeat (98) @(posedge clk);
    #1;
    chk("pp_count_last_stop", cnt_a, 2);
    push_a(8'h44, k3);
    chk("pp_edge_offset", k3 - k0, 101);
    chk("pp_count_after", cnt_a, 2);
    wait_ev(1, 600, dummy);
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    chk_rx("pp_rx", 0);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    @(posedge clk); #1;
    rxa.delete();
    push_a(8'h3C, k);
    push_a(8'hAA, k1);
    push_a(8'hBB, k2);
    repeat (42) @(posedge clk);
    #1;
    chk("rst_count_before", cnt_a, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_tx_high", tx_a, 1);
    chk("rst_count_zero", cnt_a, 0);
    chk("rst_ready_low", in_ready_a, 0);
    chk("rst_busy_low", busy_a, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_held", in_ready_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", in_ready_a, 1);
    chk("rst_release_tx", tx_a, 1);
    @(posedge clk); #1;
    push_a(8'h55, k);
    wait_ev(1, 300, dummy);
    exp_q.delete(); exp_q.push_back(8'h55);
    chk_rx("rst_rx", 0);

    // Boundary bytes.
    @(posedge clk); #1;
    rxa.delete();
    push_a(8'h00, k);
    push_a(8'hFF, k1);
    wait_ev(1, 400, dummy);
    exp_q.delete(); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    chk_rx("bound_rx", 0);

    // Default-rate instance into the line decoder.
    chk_en = 0;
    @(posedge clk); #1;
    rxb.delete();
    fork
      begin
        push_wait(1, 8'h00);
        push_wait(1, 8'h7F);
        push_wait(1, 8'h80);
        push_wait(1, 8'hFF);
        in_valid_b = 1'b0;
      end
      begin
        wait_ev(2, 100, s);
        wait_ev(3, 25000, e);
      end
    join
    chk("loop_line_time", e - s, 40 * CPB_B);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h7F);
    exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
    chk_rx("loop_rx", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
